// File: rtl/framebuffer_arbiter.sv
// framebuffer_arbiter: shares one single-port framebuffer RAM between scanout reads and renderer writes
//   Reads have priority; a write is forced after STARVE_LIMIT consecutive denied cycles.
//   Optional write buffer enabled by defining ARB_WRITE_FIFO_EN.
//   Ports: clock/reset; rdReq/rdAddr/rdGnt/rdValid/rdData (scanout);
//          wrReq/wrAddr/wrData/wrRdy/wrLevel (renderer);
//          memEn/memWe/memAddr/memWData/memRData (RAM side).
module framebuffer_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 8,
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              rdReq,
    input  logic [ADDR_W-1:0] rdAddr,
    output logic              rdGnt,
    output logic              rdValid,
    output logic [DATA_W-1:0] rdData,
    input  logic              wrReq,
    input  logic [ADDR_W-1:0] wrAddr,
    input  logic [DATA_W-1:0] wrData,
    output logic              wrRdy,
    output logic [2:0]        wrLevel,
    output logic              memEn,
    output logic              memWe,
    output logic [ADDR_W-1:0] memAddr,
    output logic [DATA_W-1:0] memWData,
    input  logic [DATA_W-1:0] memRData
);
    logic [7:0]        starveCnt;
    logic              wrPend, forceWr, rdWin, wrWin;
    logic [ADDR_W-1:0] headAddr;
    logic [DATA_W-1:0] headData;

`ifdef ARB_WRITE_FIFO_EN
    localparam int PW = $clog2(FIFO_DEPTH);
    logic [ADDR_W-1:0] fifoAddr [FIFO_DEPTH];
    logic [DATA_W-1:0] fifoData [FIFO_DEPTH];
    logic [PW:0]       headPtr, tailPtr, level;
    logic              push;
    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign level    = tailPtr - headPtr;
    assign wrPend   = level != '0;
    assign wrRdy    = level != (PW+1)'(FIFO_DEPTH);
    assign push     = wrReq && wrRdy;
    assign wrLevel  = 3'(level);
    assign headAddr = fifoAddr[headPtr[PW-1:0]];
    assign headData = fifoData[headPtr[PW-1:0]];
    always_ff @(posedge clock) begin
        if (reset) begin
            headPtr <= '0;
            tailPtr <= '0;
        end else begin
            if (push) tailPtr <= tailPtr + 1'b1;
            if (wrWin) headPtr <= headPtr + 1'b1;
        end
    end
    always_ff @(posedge clock) begin
        if (push) begin
            fifoAddr[tailPtr[PW-1:0]] <= wrAddr;
            fifoData[tailPtr[PW-1:0]] <= wrData;
        end
    end
`else
    assign wrPend   = wrReq;
    assign wrRdy    = wrWin;
    assign wrLevel  = '0;
    assign headAddr = wrAddr;
    assign headData = wrData;
`endif

    assign forceWr  = wrPend && (starveCnt == 8'(STARVE_LIMIT));
    assign rdWin    = rdReq && !forceWr;
    assign wrWin    = !rdWin && wrPend;
    assign rdGnt    = rdWin;
    assign memEn    = rdWin || wrWin;
    assign memWe    = wrWin;
    assign memAddr  = rdWin ? rdAddr : (wrWin ? headAddr : '0);
    assign memWData = wrWin ? headData : '0;

    // Counter only advances while a write is actually waiting behind a read,
    // so it never exceeds STARVE_LIMIT: at the limit the write wins and clears it.
    always_ff @(posedge clock) begin
        if (reset || !wrPend || wrWin) starveCnt <= '0;
        else if (rdWin) starveCnt <= starveCnt + 8'd1;
    end

    // Read data is captured on the same edge that raises rdValid.
    always_ff @(posedge clock) begin
        if (reset) begin
            rdValid <= 1'b0;
            rdData  <= '0;
        end else begin
            rdValid <= rdGnt;
            if (rdGnt) rdData <= memRData;
        end
    end
endmodule
